// File: rtl/vga_mem_arb.sv
// ---------------------------------------------------------------------------
// vga_mem_arb
// Display-memory arbiter between the CRT fetch, refresh (sm_ref) and CPU host
// masters and the memory cycle controller. One master owns the bus at a time
// through a registered, held grant. Each per-cycle request from the owner is
// forwarded as a single memory cycle, and the owner receives a one-cycle ack.
//
// Ports
//   mem_clk, hreset_n         clock, async active-low reset
//   *_req                     bus-ownership requests (level)
//   *_svga_req, cpu_wr        per-cycle memory request from the owner
//   crt_done, ref_cycle_done,
//   cpu_done                  owner releases the bus (1-cycle pulse)
//   mem_ack                   controller finished the current cycle
//   *_gnt                     held grants, one-hot or zero
//   crt_svga_ack, svga_ack,
//   cpu_svga_ack              per-cycle ack to CRT / refresh / CPU
//   mem_req, mem_type         cycle request to controller (00 CRT, 01 refresh,
//                             10 CPU read, 11 CPU write)
//   arb_busy                  any grant high
//
// Grant FSM
//   state  | meaning
//   G_IDLE | no owner, arbitrate on any request
//   G_OWN  | one grant held until the owner's done (or a pending done)
// Cycle FSM
//   state  | meaning
//   C_IDLE | waiting for the owner's svga_req
//   C_BUSY | mem_req held until mem_ack
//   C_HOLD | ack cycle; owner's svga_req is not sampled
// ---------------------------------------------------------------------------
module vga_mem_arb #(
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic       mem_clk,
    input  logic       hreset_n,
    input  logic       crt_req,
    input  logic       ref_req,
    input  logic       cpu_req,
    input  logic       crt_svga_req,
    input  logic       ref_svga_req,
    input  logic       cpu_svga_req,
    input  logic       cpu_wr,
    input  logic       crt_done,
    input  logic       ref_cycle_done,
    input  logic       cpu_done,
    input  logic       mem_ack,
    output logic       crt_gnt,
    output logic       ref_gnt,
    output logic       cpu_gnt,
    output logic       crt_svga_ack,
    output logic       svga_ack,
    output logic       cpu_svga_ack,
    output logic       mem_req,
    output logic [1:0] mem_type,
    output logic       arb_busy
);

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    typedef enum logic {G_IDLE, G_OWN} g_state_t;
    typedef enum logic [1:0] {C_IDLE, C_BUSY, C_HOLD} c_state_t;

    g_state_t   g_state;
    c_state_t   c_state;
    logic [3:0] cpu_wait_cnt;
    logic       done_pend;

    logic owner_done;
    logic owner_svga;
    logic g_release;
    logic cpu_first;

    assign owner_done = (crt_gnt & crt_done) | (ref_gnt & ref_cycle_done) |
                        (cpu_gnt & cpu_done);
    assign owner_svga = (crt_gnt & crt_svga_req) | (ref_gnt & ref_svga_req) |
                        (cpu_gnt & cpu_svga_req);
    // Release only once the cycle FSM is idle; a done seen mid-cycle waits.
    assign g_release  = (g_state == G_OWN) && (owner_done || done_pend) &&
                        (c_state == C_IDLE);
    assign cpu_first  = cpu_req && (cpu_wait_cnt == MAX_WAIT);
    assign arb_busy   = crt_gnt | ref_gnt | cpu_gnt;

    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            g_state      <= G_IDLE;
            crt_gnt      <= 1'b0;
            ref_gnt      <= 1'b0;
            cpu_gnt      <= 1'b0;
            done_pend    <= 1'b0;
            cpu_wait_cnt <= 4'd0;
        end else begin
            if (!cpu_req)
                cpu_wait_cnt <= 4'd0;
            case (g_state)
                G_IDLE: begin
                    if (cpu_first) begin
                        cpu_gnt      <= 1'b1;
                        cpu_wait_cnt <= 4'd0;
                        g_state      <= G_OWN;
                    end else if (crt_req || ref_req) begin
                        crt_gnt <= crt_req;
                        ref_gnt <= !crt_req;
                        if (cpu_req && cpu_wait_cnt != MAX_WAIT)
                            cpu_wait_cnt <= cpu_wait_cnt + 4'd1;
                        g_state <= G_OWN;
                    end else if (cpu_req) begin
                        cpu_gnt      <= 1'b1;
                        cpu_wait_cnt <= 4'd0;
                        g_state      <= G_OWN;
                    end
                end
                G_OWN: begin
                    if (g_release) begin
                        crt_gnt   <= 1'b0;
                        ref_gnt   <= 1'b0;
                        cpu_gnt   <= 1'b0;
                        done_pend <= 1'b0;
                        g_state   <= G_IDLE;
                    end else if (owner_done) begin
                        done_pend <= 1'b1;
                    end
                end
                default: g_state <= G_IDLE;
            endcase
        end
    end

    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            c_state      <= C_IDLE;
            mem_req      <= 1'b0;
            mem_type     <= 2'b00;
            crt_svga_ack <= 1'b0;
            svga_ack     <= 1'b0;
            cpu_svga_ack <= 1'b0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    // No new cycle on the edge that drops the grant.
                    if (owner_svga && !g_release) begin
                        mem_req  <= 1'b1;
                        mem_type <= crt_gnt ? 2'b00 :
                                    ref_gnt ? 2'b01 : {1'b1, cpu_wr};
                        c_state  <= C_BUSY;
                    end
                end
                C_BUSY: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        crt_svga_ack <= crt_gnt;
                        svga_ack     <= ref_gnt;
                        cpu_svga_ack <= cpu_gnt;
                        c_state      <= C_HOLD;
                    end
                end
                C_HOLD: begin
                    crt_svga_ack <= 1'b0;
                    svga_ack     <= 1'b0;
                    cpu_svga_ack <= 1'b0;
                    c_state      <= C_IDLE;
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arb.sv
module tb_vga_mem_arb;

    logic       mem_clk = 1'b0;
    logic       hreset_n = 1'b0;
    logic       crt_req = 1'b0, ref_req = 1'b0, cpu_req = 1'b0;
    logic       crt_svga_req = 1'b0, ref_svga_req = 1'b0, cpu_svga_req = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       crt_done = 1'b0, ref_cycle_done = 1'b0, cpu_done = 1'b0;
    logic       mem_ack = 1'b0;
    logic       crt_gnt, ref_gnt, cpu_gnt;
    logic       crt_svga_ack, svga_ack, cpu_svga_ack;
    logic       mem_req;
    logic [1:0] mem_type;
    logic       arb_busy;

    int total = 0;
    int bad   = 0;
    int acks  = 0;

    vga_mem_arb #(.CPU_MAX_WAIT(4)) dut (
        .mem_clk        (mem_clk),
        .hreset_n       (hreset_n),
        .crt_req        (crt_req),
        .ref_req        (ref_req),
        .cpu_req        (cpu_req),
        .crt_svga_req   (crt_svga_req),
        .ref_svga_req   (ref_svga_req),
        .cpu_svga_req   (cpu_svga_req),
        .cpu_wr         (cpu_wr),
        .crt_done       (crt_done),
        .ref_cycle_done (ref_cycle_done),
        .cpu_done       (cpu_done),
        .mem_ack        (mem_ack),
        .crt_gnt        (crt_gnt),
        .ref_gnt        (ref_gnt),
        .cpu_gnt        (cpu_gnt),
        .crt_svga_ack   (crt_svga_ack),
        .svga_ack       (svga_ack),
        .cpu_svga_ack   (cpu_svga_ack),
        .mem_req        (mem_req),
        .mem_type       (mem_type),
        .arb_busy       (arb_busy)
    );

    always #5 mem_clk = ~mem_clk;

    // grants as {crt,ref,cpu}, acks as {crt,ref,cpu}
    function automatic logic [7:0] gnts();
        return {5'd0, crt_gnt, ref_gnt, cpu_gnt};
    endfunction
    function automatic logic [7:0] ackv();
        return {5'd0, crt_svga_ack, svga_ack, cpu_svga_ack};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " gnt"}, gnts(), 8'd0);
        chk({tag, " ack"}, ackv(), 8'd0);
        chk({tag, " mreq"}, {7'd0, mem_req}, 8'd0);
        chk({tag, " mtype"}, {6'd0, mem_type}, 8'd0);
        chk({tag, " busy"}, {7'd0, arb_busy}, 8'd0);
    endtask

    initial begin
        #2;
        chk_reset_outs("rst");
        chk("rst cnt", {4'd0, dut.cpu_wait_cnt}, 8'd0);
        step();
        hreset_n = 1'b1;
        step();

        // refresh alone, 3 cycles
        ref_req = 1'b1;
        step();
        ref_req = 1'b0;
        chk("ref gnt", gnts(), 8'b010);
        chk("ref busy", {7'd0, arb_busy}, 8'd1);
        ref_svga_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ref mreq", {7'd0, mem_req}, 8'd1);
            chk("ref mtype", {6'd0, mem_type}, 8'd1);
            step();
            chk("ref mreq hold", {7'd0, mem_req}, 8'd1);
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            chk("ref ack", ackv(), 8'b010);
            chk("ref mreq ack", {7'd0, mem_req}, 8'd0);
            if (svga_ack) acks++;
            if (i == 2) ref_svga_req = 1'b0;
            step();
            chk("ref ack 1wide", ackv(), 8'd0);
            chk("ref mreq hold low", {7'd0, mem_req}, 8'd0);
            chk("ref gnt held", gnts(), 8'b010);
        end
        chk("ref ack count", 8'(acks), 8'd3);
        step();
        chk("ref no 4th", {7'd0, mem_req}, 8'd0);
        ref_cycle_done = 1'b1;
        step();
        ref_cycle_done = 1'b0;
        chk("ref release", gnts(), 8'd0);
        chk("ref busy rel", {7'd0, arb_busy}, 8'd0);

        // contention: CRT, REF, CPU
        crt_req = 1'b1; ref_req = 1'b1; cpu_req = 1'b1;
        step();
        crt_req = 1'b0;
        chk("cont crt", gnts(), 8'b100);
        crt_done = 1'b1;
        step();
        crt_done = 1'b0;
        chk("cont gap1", gnts(), 8'd0);
        step();
        ref_req = 1'b0;
        chk("cont ref", gnts(), 8'b010);
        chk("cont cnt", {4'd0, dut.cpu_wait_cnt}, 8'd2);
        ref_cycle_done = 1'b1;
        step();
        ref_cycle_done = 1'b0;
        chk("cont gap2", gnts(), 8'd0);
        step();
        cpu_req = 1'b0;
        chk("cont cpu", gnts(), 8'b001);
        cpu_svga_req = 1'b1; cpu_wr = 1'b1;
        step();
        chk("cpu wr mreq", {7'd0, mem_req}, 8'd1);
        chk("cpu wr mtype", {6'd0, mem_type}, 8'd3);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; cpu_svga_req = 1'b0; cpu_wr = 1'b0;
        chk("cpu ack", ackv(), 8'b001);
        step();
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        chk("cpu release", gnts(), 8'd0);

        // starvation: CRT requests continuously, CPU waits 4 grants
        cpu_req = 1'b1; crt_req = 1'b1; ref_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("starve crt", gnts(), 8'b100);
            crt_done = 1'b1;
            step();
            crt_done = 1'b0;
            chk("starve gap", gnts(), 8'd0);
        end
        chk("starve cnt max", {4'd0, dut.cpu_wait_cnt}, 8'd4);
        step();
        chk("starve cpu", gnts(), 8'b001);
        chk("starve cnt clr", {4'd0, dut.cpu_wait_cnt}, 8'd0);
        crt_req = 1'b0; ref_req = 1'b0; cpu_req = 1'b0;
        cpu_done = 1'b1;
        step();
        cpu_done = 1'b0;
        chk("starve rel", gnts(), 8'd0);

        // early done during C_BUSY
        crt_req = 1'b1;
        step();
        crt_req = 1'b0;
        chk("early gnt", gnts(), 8'b100);
        crt_svga_req = 1'b1;
        step();
        crt_svga_req = 1'b0;
        chk("early mtype", {6'd0, mem_type}, 8'd0);
        chk("early mreq", {7'd0, mem_req}, 8'd1);
        crt_done = 1'b1;
        step();
        crt_done = 1'b0;
        chk("early held1", gnts(), 8'b100);
        step();
        chk("early held2", gnts(), 8'b100);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("early ack", ackv(), 8'b100);
        chk("early held3", gnts(), 8'b100);
        step();
        chk("early held4", gnts(), 8'b100);
        step();
        chk("early rel", gnts(), 8'd0);

        // non-owner svga_req and spurious mem_ack
        ref_req = 1'b1;
        step();
        ref_req = 1'b0;
        cpu_svga_req = 1'b1;
        step();
        step();
        chk("abuse mreq", {7'd0, mem_req}, 8'd0);
        cpu_svga_req = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("abuse ack", ackv(), 8'd0);
        step();
        chk("abuse ack2", ackv(), 8'd0);
        chk("abuse mreq2", {7'd0, mem_req}, 8'd0);
        ref_cycle_done = 1'b1;
        step();
        ref_cycle_done = 1'b0;
        chk("abuse rel", gnts(), 8'd0);

        // reset during C_BUSY
        crt_req = 1'b1;
        step();
        crt_req = 1'b0;
        crt_svga_req = 1'b1;
        step();
        crt_svga_req = 1'b0;
        chk("pre-rst mreq", {7'd0, mem_req}, 8'd1);
        hreset_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        step();
        hreset_n = 1'b1;
        step();
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        chk("post-rst gnt", gnts(), 8'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_mem_arb.md
# vga_mem_arb

VGA display-memory arbiter sitting between the VGA memory masters (CRT fetch, refresh state machine `sm_ref`, CPU host access) and the memory cycle controller. It grants ownership of the memory bus to one master at a time with a held, registered grant. It forwards each of the owner's per-cycle requests to the controller as a single memory cycle and returns a one-cycle acknowledge to the owner. It consumes `ref_req`, `ref_svga_req` and `ref_cycle_done`, and produces `ref_gnt` and the `svga_ack` seen by the refresh state machine.

## Interface
- `CPU_MAX_WAIT`, 4: number of CRT/REF grants issued while `cpu_req` waits before CPU gets top priority; range 1–15.
- `mem_clk`  in  1  memory clock; all logic on rising edge.
- `hreset_n`  in  1  asynchronous active-low reset.
- `crt_req`, `ref_req`, `cpu_req`  in  1 each  bus-ownership requests (level).
- `crt_svga_req`, `ref_svga_req`, `cpu_svga_req`  in  1 each  per-cycle memory request from owner.
- `cpu_wr`  in  1  CPU cycle is a write; sampled with `cpu_svga_req`.
- `crt_done`, `ref_cycle_done`, `cpu_done`  in  1 each  owner releases bus (1-cycle pulse).
- `mem_ack`  in  1  controller completed current cycle (1-cycle pulse).
- `crt_gnt`, `ref_gnt`, `cpu_gnt`  out  1 each  registered, held grants; at most one high.
- `crt_svga_ack`, `svga_ack`, `cpu_svga_ack`  out  1 each  per-cycle ack to CRT / refresh / CPU.
- `mem_req`  out  1  memory cycle request to controller, held until `mem_ack`.
- `mem_type`  out  2  00 CRT read, 01 refresh, 10 CPU read, 11 CPU write.
- `arb_busy`  out  1  any grant high.

## Operation
- Two cooperating FSMs: the grant FSM (G_IDLE, G_OWN) and the cycle FSM (C_IDLE, C_BUSY, C_HOLD).
- G_IDLE: on an edge with any request high, pick a winner, set its gnt and go to G_OWN. Priority is CRT > REF > CPU. When `cpu_wait_cnt == CPU_MAX_WAIT` and `cpu_req` is high, the order is CPU > CRT > REF.
- Grants must not depend combinationally on any request: `ref_req` drops combinationally when `ref_gnt` rises.
- G_OWN: hold gnt until the owner's done is sampled. Done from a non-owner is ignored. If done arrives while the cycle FSM is not in C_IDLE, latch it as pending and release when the cycle FSM returns to C_IDLE.
- Release: the gnt clears at the edge that samples done (or the pending release), and the FSM enters G_IDLE.
- `cpu_wait_cnt` (4 bit):
  - increments, saturating at `CPU_MAX_WAIT`, on each CRT/REF grant issued while `cpu_req` is high;
  - clears on a CPU grant, or on any edge with `cpu_req` low.
- C_IDLE: with an owner and that owner's svga_req high at the edge:
  - set `mem_req` and `mem_type` (CPU: `{1, cpu_wr}`);
  - go to C_BUSY.
  - svga_req from non-owners is ignored.
- C_BUSY: hold `mem_req`/`mem_type` stable. On `mem_ack`: clear `mem_req`, pulse the owner's ack for one cycle, go to C_HOLD.
- C_HOLD: one cycle in which the owner's svga_req is not sampled (it is still high during the ack cycle). Then return to C_IDLE.
- The owner may issue any number of cycles per grant. The refresh owner issues 3 or 5 (per CR11 bit 6) before `ref_cycle_done`.

## Timing
- Reset values: all gnt 0, all acks 0, `mem_req` 0, `mem_type` 00, `arb_busy` 0, `cpu_wait_cnt` 0, both FSMs idle.
- Request-to-grant: a request sampled at edge N gives gnt high after edge N. Earliest back-to-back re-grant is one edge after release, so gnt is low for at least 1 cycle between owners.
- svga_req-to-`mem_req`: 1 cycle.
- `mem_ack`-to-owner ack: 1 cycle; ack is exactly 1 cycle wide and coincides with `mem_req` low.
- Minimum spacing between consecutive cycles of one owner: `mem_req` low for at least 2 cycles (ack cycle + C_HOLD).
- `mem_ack` outside C_BUSY is ignored.
- Requests and done in the same cycle from different masters: done is processed first, and the new grant issues on the following edge.
- Reset mid-cycle clears everything immediately; the controller must abandon any outstanding cycle.

## Test plan
- Refresh alone: `ref_req` pulse, 3 `ref_svga_req` cycles with `mem_ack` 2 cycles after each `mem_req` → `ref_gnt` held throughout, 3 `svga_ack` pulses, `mem_type`=01, `ref_gnt` low the edge after `ref_cycle_done`.
- Contention: `crt_req`, `ref_req` and `cpu_req` high together → grant order CRT, REF, CPU, with ≥1 idle cycle between grants.
- Starvation: `cpu_req` held while CRT/REF re-request continuously, `CPU_MAX_WAIT`=4 → CPU granted after exactly 4 CRT/REF grants even with `crt_req` high; counter reads 0 after.
- Early done: owner pulses done while C_BUSY → grant held until ack completes, then released; no dropped ack.
- Non-owner/ack abuse: `cpu_svga_req` during `ref_gnt`, and a spurious `mem_ack` in C_IDLE → no `mem_req`, no acks.
- Reset: assert `hreset_n` low during C_BUSY → all outputs at reset values immediately; normal grant on the first request after release.
